cordic_iter_ctrl: RTL and testbench

CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

---
 rtl/cordic_iter_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_ctrl.sv
// -----------------------------------------------------------------------------
// cordic_iter_ctrl
//
// Iteration controller for an iterative CORDIC engine. The arithmetic core is
// combinational and lives outside this block: this block holds the current
// x/y/z state, the rotation direction, the mode and the shift amount, feeds
// them to the core, and registers the core's next-state outputs once per
// clock until the last iteration. It then publishes the result and pulses
// o_done.
//
// Modes
//   circular   (i_mode = 1): shifts 0 .. p_CIRC_ITER-1, atan(2^-i) table
//   hyperbolic (i_mode = 0): shifts 1 .. p_HYP_ITER,    atanh(2^-i) table
//   Angles use the full 32-bit circle (2^32 = 360 degrees).
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start, i_mode       start request (sampled in IDLE only), mode select
//   i_x, i_y, i_z         initial state, captured on an accepted start
//   i_core_x/y/z          next-state outputs of the external core
//   o_xprev/yprev/zprev   current-state registers into the core
//   o_dprev               rotation direction into the core (1 = positive)
//   o_mode                registered mode into the core
//   o_shift_amnt          current iteration index / shift amount
//   o_lut                 rotation angle for the current shift (combinational)
//   o_x, o_y, o_z         final results, held until the next completion
//   o_busy                high while iterating
//   o_done                one-cycle pulse when o_x/o_y/o_z are updated
// -----------------------------------------------------------------------------
module cordic_iter_ctrl #(
  parameter int p_WIDTH     = 32,
  parameter int p_CIRC_ITER = 20,
  parameter int p_HYP_ITER  = 19
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
  input  logic [p_WIDTH-1:0] i_z,
  input  logic [p_WIDTH-1:0] i_core_x,
  input  logic [p_WIDTH-1:0] i_core_y,
  input  logic [p_WIDTH-1:0] i_core_z,
  output logic [p_WIDTH-1:0] o_xprev,
  output logic [p_WIDTH-1:0] o_yprev,
  output logic [p_WIDTH-1:0] o_zprev,
  output logic               o_dprev,
  output logic               o_mode,
  output logic [4:0]         o_shift_amnt,
  output logic [p_WIDTH-1:0] o_lut,
  output logic [p_WIDTH-1:0] o_x,
  output logic [p_WIDTH-1:0] o_y,
  output logic [p_WIDTH-1:0] o_z,
  output logic               o_busy,
  output logic               o_done
);

  // Final shift index for each mode; both are 19 with the default parameters.
  localparam logic [4:0] LP_CIRC_LAST  = 5'(p_CIRC_ITER - 1);
  localparam logic [4:0] LP_HYP_LAST   = 5'(p_HYP_ITER);
  localparam logic [4:0] LP_CIRC_FIRST = 5'd0;
  // Hyperbolic CORDIC has no shift-0 step (atanh(1) is infinite).
  localparam logic [4:0] LP_HYP_FIRST  = 5'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [p_WIDTH-1:0] xprev_q, xprev_d;
  logic [p_WIDTH-1:0] yprev_q, yprev_d;
  logic [p_WIDTH-1:0] zprev_q, zprev_d;
  logic               dprev_q, dprev_d;
  logic               mode_q, mode_d;
  logic [4:0]         shift_q, shift_d;
  logic [p_WIDTH-1:0] x_q, x_d;
  logic [p_WIDTH-1:0] y_q, y_d;
  logic [p_WIDTH-1:0] z_q, z_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [4:0]         last_shift_s;

  // atan(2^-i) in units of 2^32 = 360 degrees.
  function automatic logic [31:0] circ_rom(input logic [4:0] idx);
    logic [31:0] val;
    case (idx)
      5'd0:    val = 32'h2000_0000;
      5'd1:    val = 32'h12E4_051D;
      5'd2:    val = 32'h09FB_385B;
      5'd3:    val = 32'h0511_11D4;
      5'd4:    val = 32'h028B_0D43;
      5'd5:    val = 32'h0145_D7E1;
      5'd6:    val = 32'h00A2_F61E;
      5'd7:    val = 32'h0051_7C55;
      5'd8:    val = 32'h0028_BE53;
      5'd9:    val = 32'h0014_5F2E;
      5'd10:   val = 32'h000A_2F98;
      5'd11:   val = 32'h0005_17CC;
      5'd12:   val = 32'h0002_8BE6;
      5'd13:   val = 32'h0001_45F3;
      5'd14:   val = 32'h0000_A2F9;
      5'd15:   val = 32'h0000_517C;
      5'd16:   val = 32'h0000_28BE;
      5'd17:   val = 32'h0000_145F;
      5'd18:   val = 32'h0000_0A2F;
      5'd19:   val = 32'h0000_0517;
      default: val = 32'h0000_0000;
    endcase
    return val;
  endfunction

  // atanh(2^-i); beyond shift 9 it agrees with atan to 32-bit precision,
  // so the upper entries are shared with the circular table.
  function automatic logic [31:0] hyp_rom(input logic [4:0] idx);
    logic [31:0] val;
    case (idx)
      5'd0:    val = 32'h0000_0000;
      5'd1:    val = 32'h1661_788D;
      5'd2:    val = 32'h0A68_0D61;
      5'd3:    val = 32'h051E_A6FC;
      5'd4:    val = 32'h028C_BFDD;
      5'd5:    val = 32'h0146_0E34;
      5'd6:    val = 32'h00A2_FCE8;
      5'd7:    val = 32'h0051_7D2E;
      5'd8:    val = 32'h0028_BE6E;
      5'd9:    val = 32'h0014_5F32;
      default: val = circ_rom(idx);
    endcase
    return val;
  endfunction

  // Angle lookup for the iteration currently presented to the core.
  always_comb begin
    if (mode_q) begin
      o_lut = circ_rom(shift_q);
    end else begin
      o_lut = hyp_rom(shift_q);
    end
  end

  // Last shift index of the running mode.
  always_comb begin
    if (mode_q) begin
      last_shift_s = LP_CIRC_LAST;
    end else begin
      last_shift_s = LP_HYP_LAST;
    end
  end

  // Next-state logic: FSM transitions and all datapath register updates.
  always_comb begin
    state_d = state_q;
    xprev_d = xprev_q;
    yprev_d = yprev_q;
    zprev_d = zprev_q;
    dprev_d = dprev_q;
    mode_d  = mode_q;
    shift_d = shift_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          xprev_d = i_x;
          yprev_d = i_y;
          zprev_d = i_z;
          mode_d  = i_mode;
          // Rotate towards zero: positive step while z is non-negative.
          dprev_d = ~i_z[p_WIDTH-1];
          if (i_mode) begin
            shift_d = LP_CIRC_FIRST;
          end else begin
            shift_d = LP_HYP_FIRST;
          end
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        xprev_d = i_core_x;
        yprev_d = i_core_y;
        zprev_d = i_core_z;
        dprev_d = ~i_core_z[p_WIDTH-1];
        if (shift_q == last_shift_s) begin
          // Final iteration: publish, and hold the shift so it never
          // steps past the table.
          x_d     = i_core_x;
          y_d     = i_core_y;
          z_d     = i_core_z;
          state_d = ST_DONE;
        end else begin
          shift_d = shift_q + 5'd1;
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so they line up with it.
  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      xprev_q <= '0;
      yprev_q <= '0;
      zprev_q <= '0;
      dprev_q <= 1'b1;
      mode_q  <= 1'b0;
      shift_q <= 5'd0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xprev_q <= xprev_d;
      yprev_q <= yprev_d;
      zprev_q <= zprev_d;
      dprev_q <= dprev_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_xprev      = xprev_q;
  assign o_yprev      = yprev_q;
  assign o_zprev      = zprev_q;
  assign o_dprev      = dprev_q;
  assign o_mode       = mode_q;
  assign o_shift_amnt = shift_q;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_z          = z_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for cordic_iter_ctrl. A behavioural CORDIC core closes the loop
// from the controller's current-state outputs to its i_core_* inputs.
// Expected results are queued when a run is started; a monitor pops and
// compares them whenever o_done pulses.
// -----------------------------------------------------------------------------
module tb_cordic_iter_ctrl;

  logic        clk;
  logic        i_rst, i_start, i_mode;
  logic [31:0] i_x, i_y, i_z;
  logic [31:0] core_x, core_y, core_z;
  logic [31:0] o_xprev, o_yprev, o_zprev, o_lut, o_x, o_y, o_z;
  logic        o_dprev, o_mode, o_busy, o_done;
  logic [4:0]  o_shift_amnt;

  cordic_iter_ctrl dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_mode       (i_mode),
    .i_x          (i_x),
    .i_y          (i_y),
    .i_z          (i_z),
    .i_core_x     (core_x),
    .i_core_y     (core_y),
    .i_core_z     (core_z),
    .o_xprev      (o_xprev),
    .o_yprev      (o_yprev),
    .o_zprev      (o_zprev),
    .o_dprev      (o_dprev),
    .o_mode       (o_mode),
    .o_shift_amnt (o_shift_amnt),
    .o_lut        (o_lut),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_z          (o_z),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural CORDIC core.
  logic signed [31:0] sx, sy;
  always_comb begin
    sx = $signed(o_xprev) >>> o_shift_amnt;
    sy = $signed(o_yprev) >>> o_shift_amnt;
    if (o_mode) begin
      if (o_dprev) begin
        core_x = o_xprev - sy;  core_y = o_yprev + sx;  core_z = o_zprev - o_lut;
      end else begin
        core_x = o_xprev + sy;  core_y = o_yprev - sx;  core_z = o_zprev + o_lut;
      end
    end else begin
      if (o_dprev) begin
        core_x = o_xprev + sy;  core_y = o_yprev + sx;  core_z = o_zprev - o_lut;
      end else begin
        core_x = o_xprev - sy;  core_y = o_yprev - sx;  core_z = o_zprev + o_lut;
      end
    end
  end

  // Reference angle tables.
  logic [31:0] circ_tab [20] = '{
    32'h20000000, 32'h12E4051D, 32'h09FB385B, 32'h051111D4, 32'h028B0D43,
    32'h0145D7E1, 32'h00A2F61E, 32'h00517C55, 32'h0028BE53, 32'h00145F2E,
    32'h000A2F98, 32'h000517CC, 32'h00028BE6, 32'h000145F3, 32'h0000A2F9,
    32'h0000517C, 32'h000028BE, 32'h0000145F, 32'h00000A2F, 32'h00000517};
  logic [31:0] hyp_tab [10] = '{
    32'h00000000, 32'h1661788D, 32'h0A680D61, 32'h051EA6FC, 32'h028CBFDD,
    32'h01460E34, 32'h00A2FCE8, 32'h00517D2E, 32'h0028BE6E, 32'h00145F32};

  function automatic logic [31:0] ref_lut(input logic m, input logic [4:0] i);
    if (i > 5'd19) return 32'h0;
    if (!m && i < 5'd10) return hyp_tab[i];
    return circ_tab[i];
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_real(input string name, input real act, input real req, input real tol);
    checks++;
    if ((act - req) > tol || (req - act) > tol) begin
      errors++;
      $display("FAIL %s: got %f expected %f", name, act, req);
    end
  endtask

  typedef struct {
    int  done_cyc;
    real ex;
    real ey;
    real scale;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Scoreboard monitor: every o_done pulse must match a queued run.
  always @(negedge clk) begin
    if (o_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got o_done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
        chk_real("result_x", $itor($signed(o_x)) / mon_e.scale, mon_e.ex, 1.0e-5);
        chk_real("result_y", $itor($signed(o_y)) / mon_e.scale, mon_e.ey, 1.0e-5);
      end
    end
  end

  // Angle table check for every shift visited while iterating.
  always @(negedge clk) begin
    if (o_busy) chk("lut", o_lut, ref_lut(o_mode, o_shift_amnt));
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_xprev"}, o_xprev, 32'h0);
    chk({tag, "_yprev"}, o_yprev, 32'h0);
    chk({tag, "_zprev"}, o_zprev, 32'h0);
    chk({tag, "_x"}, o_x, 32'h0);
    chk({tag, "_y"}, o_y, 32'h0);
    chk({tag, "_z"}, o_z, 32'h0);
    chk({tag, "_shift"}, 32'(o_shift_amnt), 32'h0);
    chk({tag, "_flags"}, {28'h0, o_mode, o_dprev, o_busy, o_done}, 32'h4);
  endtask

  // Start a run from a negedge; returns at the negedge after the accept edge.
  task automatic run(input logic m, input logic [31:0] x0, input logic [31:0] y0,
                     input logic [31:0] z0, input real ex, input real ey,
                     input logic exp_d, input bit corrupt, input bit want);
    exp_t e;
    int   n;
    n = m ? 20 : 19;
    i_mode = m; i_x = x0; i_y = y0; i_z = z0; i_start = 1'b1;
    if (want) begin
      e.done_cyc = cyc + 1 + n;
      e.ex = ex; e.ey = ey;
      e.scale = m ? 2.0 ** 31 : 2.0 ** 28;
      sb.push_back(e);
    end
    @(negedge clk);
    i_start = 1'b0;
    chk("start_busy", 32'(o_busy), 32'h1);
    chk("start_shift", 32'(o_shift_amnt), m ? 32'h0 : 32'h1);
    chk("start_dprev", 32'(o_dprev), 32'(exp_d));
    chk("start_mode", 32'(o_mode), 32'(m));
    chk("start_xprev", o_xprev, x0);
    if (corrupt) begin
      i_x = $urandom; i_y = $urandom; i_z = $urandom; i_mode = ~m;
    end
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 120; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  localparam real COS10 = 0.98480775;
  localparam real SIN10 = 0.17364818;
  localparam real COSH  = 1.01526957;
  localparam real SINH  = 0.17542038;

  logic [31:0] hx0;
  bit          hit;

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_mode = 1'b0;
    i_x = 32'h0; i_y = 32'h0; i_z = 32'h0;
    hx0 = 32'($rtoi(1.2051363584 * (2.0 ** 28)));
    repeat (3) @(negedge clk);
    chk_reset("reset");
    chk("reset_lut", o_lut, 32'h0);
    i_rst = 1'b0;
    @(negedge clk);

    // Circular +10 degrees, inputs disturbed after acceptance.
    run(1'b1, 32'h4DBA76D4, 32'h0, 32'h071C71C7, COS10, SIN10, 1'b1, 1'b1, 1'b1);
    wait_empty("circ_pos");
    repeat (2) @(negedge clk);

    // Circular -10 degrees.
    run(1'b1, 32'h4DBA76D4, 32'h0, 32'hF8E38E39, COS10, -SIN10, 1'b0, 1'b1, 1'b1);
    wait_empty("circ_neg");
    repeat (2) @(negedge clk);

    // Hyperbolic 0.174533 rad.
    run(1'b0, hx0, 32'h0, 32'h071C71C7, COSH, SINH, 1'b1, 1'b1, 1'b1);
    wait_empty("hyp");
    repeat (2) @(negedge clk);

    // Start pulse in the middle of a run is ignored.
    run(1'b1, 32'h4DBA76D4, 32'h0, 32'h071C71C7, COS10, SIN10, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    i_start = 1'b1; i_mode = 1'b0; i_z = 32'h12345678;
    @(negedge clk);
    i_start = 1'b0; i_mode = 1'b1; i_z = 32'h071C71C7;
    chk("ignore_shift", 32'(o_shift_amnt), 32'h5);
    chk("ignore_mode", 32'(o_mode), 32'h1);
    wait_empty("ignore");
    repeat (5) @(negedge clk);

    // Start held high: two runs with one IDLE cycle between them.
    begin
      exp_t e;
      i_mode = 1'b1; i_x = 32'h4DBA76D4; i_y = 32'h0; i_z = 32'hF8E38E39;
      i_start = 1'b1;
      e.ex = COS10; e.ey = -SIN10; e.scale = 2.0 ** 31;
      e.done_cyc = cyc + 21;
      sb.push_back(e);
      e.done_cyc = cyc + 43;
      sb.push_back(e);
      repeat (22) @(negedge clk);
      chk("gap_idle", {30'h0, o_busy, o_done}, 32'h0);
      @(negedge clk);
      chk("restart_busy", 32'(o_busy), 32'h1);
      i_start = 1'b0;
      wait_empty("hold");
      repeat (3) @(negedge clk);
    end

    // Reset at shift 7 aborts the run; reset beats a same-edge start.
    run(1'b1, 32'h4DBA76D4, 32'h0, 32'h071C71C7, 0.0, 0.0, 1'b1, 1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_shift_amnt == 5'd7) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reach7", 32'(hit), 32'h1);
    i_rst = 1'b1; i_start = 1'b1;
    @(negedge clk);
    chk_reset("abort");
    i_rst = 1'b0; i_start = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_idle_busy", 32'(o_busy), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
